// File: rtl/mdio_reg_if_apb_bridge.sv
// mdio_reg_if_apb_bridge
// Turns each reg_if request from the MDIO backend into one APB3 master
// transfer. A hung slave is cut off by an access-phase timeout, and both
// timeouts and slave errors return a fixed error word and set a sticky flag.
module mdio_reg_if_apb_bridge #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [15:0] ERR_RDATA   = 16'hFFFF
) (
  input  logic        clk_25m,
  input  logic        rst,
  // backend request side
  input  logic        reg_if_valid,
  input  logic [20:0] reg_if_addr,
  input  logic [15:0] reg_if_wdata,
  input  logic        reg_if_we,
  output logic [15:0] reg_if_rdata,
  output logic        reg_if_ready,
  // APB3 master side
  output logic [20:0] paddr,
  output logic [15:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  // error reporting
  input  logic        err_clr,
  output logic        timeout_pulse,
  output logic        err_sticky
);

  // The counter only has to reach TIMEOUT_CYC-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_ACCESS   = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [20:0]      r_paddr;
  logic [15:0]      r_pwdata;
  logic             r_pwrite;
  logic [15:0]      r_rdata;
  logic             r_err_sticky;

  logic w_access;
  logic w_done;
  logic w_timeout;
  logic w_capture;

  // Data handed back on a completed access: slave errors override the read
  // data, and writes return zero so stale prdata never leaks to the backend.
  function automatic logic [15:0] resp_data(input logic        slverr,
                                            input logic        is_write,
                                            input logic [15:0] rd);
    if (slverr)
      resp_data = ERR_RDATA;
    else if (is_write)
      resp_data = 16'h0000;
    else
      resp_data = rd;
  endfunction

  assign w_access  = (r_state == S_ACCESS);
  assign w_done    = w_access & pready;
  // pready on the last allowed cycle still counts as a normal completion.
  assign w_timeout = w_access & ~pready & (r_cnt == CNT_LAST);
  assign w_capture = (r_state == S_IDLE) & reg_if_valid;

  // Transfer sequencing: one APB transfer per backend request.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (reg_if_valid) r_state <= S_SETUP;
        S_SETUP:    r_state <= S_ACCESS;
        S_ACCESS:   if (w_done || w_timeout) r_state <= S_RESP;
        S_RESP:     r_state <= S_WAIT_LOW;
        S_WAIT_LOW: if (!reg_if_valid) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Request capture; later changes on the request bus are ignored.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (w_capture) begin
      r_paddr  <= reg_if_addr;
      r_pwdata <= reg_if_wdata;
      r_pwrite <= reg_if_we;
    end
  end

  // Access-phase wait counter, restarted in SETUP.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if (w_access && !pready && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Response data latch, loaded when the access phase ends.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_done) begin
      r_rdata <= resp_data(pslverr, r_pwrite, prdata);
    end else if (w_timeout) begin
      r_rdata <= ERR_RDATA;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if ((w_done && pslverr) || w_timeout) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  // Bus strobes decode straight from state so reset drops them immediately.
  assign psel          = (r_state == S_SETUP) | w_access;
  assign penable       = w_access;
  assign paddr         = r_paddr;
  assign pwdata        = r_pwdata;
  assign pwrite        = r_pwrite;
  assign reg_if_ready  = (r_state == S_RESP);
  assign reg_if_rdata  = (r_state == S_RESP) ? r_rdata : 16'h0000;
  assign timeout_pulse = w_timeout;
  assign err_sticky    = r_err_sticky;

endmodule

// File: tb/tb_mdio_reg_if_apb_bridge.sv
// Bench for mdio_reg_if_apb_bridge: a reactive APB slave plus a
// transaction-level model of the expected response for each request.
module tb_mdio_reg_if_apb_bridge;

  localparam int          TO  = 64;
  localparam logic [15:0] ERR = 16'hFFFF;

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;
  logic        reg_if_valid = 1'b0;
  logic [20:0] reg_if_addr = '0;
  logic [15:0] reg_if_wdata = '0;
  logic        reg_if_we = 1'b0;
  logic [15:0] reg_if_rdata;
  logic        reg_if_ready;
  logic [20:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [15:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        err_clr = 1'b0;
  logic        timeout_pulse;
  logic        err_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_sticky = 1'b0;

  mdio_reg_if_apb_bridge #(.TIMEOUT_CYC(TO), .ERR_RDATA(ERR)) dut (
    .clk_25m(clk_25m), .rst(rst),
    .reg_if_valid(reg_if_valid), .reg_if_addr(reg_if_addr),
    .reg_if_wdata(reg_if_wdata), .reg_if_we(reg_if_we),
    .reg_if_rdata(reg_if_rdata), .reg_if_ready(reg_if_ready),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .err_clr(err_clr), .timeout_pulse(timeout_pulse), .err_sticky(err_sticky)
  );

  always #20 clk_25m = ~clk_25m;

  // One request/response, called at a negedge with the DUT idle. The slave
  // answers after `waits` access cycles (never, if waits >= TO).
  task automatic run_xfer(input logic [20:0] addr, input logic [15:0] wdata,
                          input logic we, input int waits, input logic slverr,
                          input logic [15:0] rd, input int hold,
                          input bit drop_early, input string name);
    int k, rcyc, tpcyc, dcyc, n_tp, n_set, n_acc, n_rdy, n_bad, n_abad;
    bit exp_to, done, got_stk;
    int exp_acc;
    logic [15:0] exp_rd, got_rd;
    k = 0; rcyc = -1; tpcyc = -1; n_tp = 0; n_set = 0; n_acc = 0;
    n_rdy = 0; n_bad = 0; n_abad = 0; done = 0; got_stk = 0; got_rd = '0;
    exp_to  = (waits >= TO);
    exp_acc = exp_to ? TO : waits + 1;
    exp_rd  = (exp_to || slverr) ? ERR : (we ? 16'h0000 : rd);
    dcyc    = drop_early ? 0 : -1;
    reg_if_valid = 1'b1; reg_if_addr = addr; reg_if_wdata = wdata; reg_if_we = we;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk_25m);
      if (psel && (paddr !== addr || pwdata !== wdata || pwrite !== we)) n_abad++;
      if (psel && !penable) n_set++;
      if (psel && penable) begin
        n_acc++;
        pready  = (k == waits);
        pslverr = pready & slverr;
        prdata  = pready ? rd : 16'($urandom);
        k++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = 16'($urandom);
      end
      #1;
      if (timeout_pulse) begin n_tp++; tpcyc = cyc; end
      if (reg_if_ready) begin
        n_rdy++;
        if (rcyc < 0) begin rcyc = cyc; got_rd = reg_if_rdata; got_stk = err_sticky; end
      end else if (reg_if_rdata !== 16'h0000) begin
        n_bad++;
      end
      if (cyc == 0) begin
        reg_if_addr = 21'($urandom); reg_if_wdata = 16'($urandom); reg_if_we = ~we;
      end
      if (drop_early && cyc == 0) reg_if_valid = 1'b0;
      if (rcyc >= 0 && !drop_early && cyc == rcyc + hold) begin
        reg_if_valid = 1'b0; dcyc = cyc;
      end
      if (rcyc >= 0 && dcyc >= 0 && cyc >= rcyc + 2 && cyc >= dcyc + 1) done = 1;
    end
    pready = 1'b0; pslverr = 1'b0;
    if (exp_to || slverr) exp_sticky = 1'b1;
    else if (err_clr)     exp_sticky = 1'b0;

    n_tests++; if (!done) begin n_fail++;
      $display("FAIL %s completion: no ready within cycle budget", name); end
    n_tests++; if (n_set !== 1) begin n_fail++;
      $display("FAIL %s setup_count: got %0d want 1", name, n_set); end
    n_tests++; if (n_acc !== exp_acc) begin n_fail++;
      $display("FAIL %s access_cycles: got %0d want %0d", name, n_acc, exp_acc); end
    n_tests++; if (rcyc !== exp_acc + 1) begin n_fail++;
      $display("FAIL %s ready_cycle: got %0d want %0d", name, rcyc, exp_acc + 1); end
    n_tests++; if (n_rdy !== 1) begin n_fail++;
      $display("FAIL %s ready_pulses: got %0d want 1", name, n_rdy); end
    n_tests++; if (got_rd !== exp_rd) begin n_fail++;
      $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd); end
    n_tests++; if (n_tp !== (exp_to ? 1 : 0)) begin n_fail++;
      $display("FAIL %s timeout_pulses: got %0d want %0d", name, n_tp, exp_to ? 1 : 0); end
    if (exp_to) begin
      n_tests++; if (tpcyc !== rcyc - 1) begin n_fail++;
        $display("FAIL %s timeout_pos: got cycle %0d want %0d", name, tpcyc, rcyc - 1); end
    end
    n_tests++; if (got_stk !== exp_sticky) begin n_fail++;
      $display("FAIL %s err_sticky: got %b want %b", name, got_stk, exp_sticky); end
    n_tests++; if (n_abad !== 0) begin n_fail++;
      $display("FAIL %s apb_addr_data: %0d bad cycles want 0", name, n_abad); end
    n_tests++; if (n_bad !== 0) begin n_fail++;
      $display("FAIL %s rdata_idle: %0d nonzero cycles want 0", name, n_bad); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_25m);
    @(negedge clk_25m);
    n_tests++; if ({psel, penable, reg_if_ready, pwrite, timeout_pulse, err_sticky} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {psel, penable, reg_if_ready, pwrite, timeout_pulse, err_sticky}); end
    n_tests++; if (paddr !== 21'h0) begin n_fail++;
      $display("FAIL reset_paddr: got %h want 0", paddr); end
    n_tests++; if (pwdata !== 16'h0 || reg_if_rdata !== 16'h0) begin n_fail++;
      $display("FAIL reset_data: pwdata %h rdata %h want 0", pwdata, reg_if_rdata); end
    rst = 1'b0;
    exp_sticky = 1'b0;
    @(negedge clk_25m);
  endtask

  task automatic test_read_zero_wait();
    run_xfer(21'h01_0002, 16'($urandom), 1'b0, 0, 1'b0, 16'h1234, 0, 1'b0, "read_zero_wait");
  endtask

  task automatic test_write_waits();
    run_xfer(21'h00_0ABC, 16'hA5A5, 1'b1, 5, 1'b0, 16'h7777, 4, 1'b0, "write_5wait");
  endtask

  task automatic test_timeout();
    run_xfer(21'h1F_0001, 16'h0, 1'b0, 1000, 1'b0, 16'h2222, 0, 1'b0, "timeout");
    err_clr = 1'b1;
    @(negedge clk_25m);
    err_clr = 1'b0;
    exp_sticky = 1'b0;
    n_tests++; if (err_sticky !== exp_sticky) begin n_fail++;
      $display("FAIL err_clr: got %b want %b", err_sticky, exp_sticky); end
  endtask

  task automatic test_pslverr();
    run_xfer(21'h00_0010, 16'h0, 1'b0, 0, 1'b1, 16'h5555, 0, 1'b0, "pslverr");
    err_clr = 1'b1; @(negedge clk_25m); err_clr = 1'b0; exp_sticky = 1'b0;
    run_xfer(21'h00_0020, 16'h0, 1'b0, TO - 1, 1'b0, 16'h4321, 0, 1'b0, "ready_last_cycle");
  endtask

  task automatic test_err_clr_collide();
    err_clr = 1'b1;
    run_xfer(21'h00_0030, 16'h0, 1'b0, 2, 1'b1, 16'h9999, 0, 1'b0, "set_beats_clr");
    @(negedge clk_25m);
    err_clr = 1'b0;
    exp_sticky = 1'b0;
    n_tests++; if (err_sticky !== exp_sticky) begin n_fail++;
      $display("FAIL clr_after_collide: got %b want %b", err_sticky, exp_sticky); end
  endtask

  task automatic test_reset_mid();
    int na;
    na = 0;
    reg_if_valid = 1'b1; reg_if_addr = 21'h00_0040; reg_if_we = 1'b0;
    for (int c = 0; c < 10 && na < 2; c++) begin
      @(negedge clk_25m);
      pready = 1'b0;
      if (psel && penable) na++;
    end
    n_tests++; if (na !== 2) begin n_fail++;
      $display("FAIL rst_mid_reach: access cycles got %0d want 2", na); end
    rst = 1'b1;
    #1;
    n_tests++; if ({psel, penable, reg_if_ready} !== 3'b000) begin n_fail++;
      $display("FAIL rst_mid_async: got %b want 000", {psel, penable, reg_if_ready}); end
    reg_if_valid = 1'b0;
    @(negedge clk_25m);
    n_tests++; if ({psel, penable, reg_if_ready, err_sticky} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_mid_hold: got %b want 0000", {psel, penable, reg_if_ready, err_sticky}); end
    rst = 1'b0;
    exp_sticky = 1'b0;
    @(negedge clk_25m);
    run_xfer(21'h00_0041, 16'h0, 1'b0, 1, 1'b0, 16'hBEEF, 0, 1'b0, "after_rst_read");
  endtask

  task automatic test_back_to_back();
    run_xfer(21'h0A_0001, 16'h1111, 1'b1, 0, 1'b0, 16'h0, 1, 1'b0, "b2b_first");
    run_xfer(21'h0B_0002, 16'h0, 1'b0, 2, 1'b0, 16'hCAFE, 0, 1'b0, "b2b_second");
    run_xfer(21'h0C_0003, 16'h0, 1'b0, 3, 1'b0, 16'hD00D, 0, 1'b1, "early_drop");
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       w = TO - 1 + int'($urandom_range(0, 2));
        default: w = int'($urandom_range(0, 8));
      endcase
      run_xfer(21'($urandom), 16'($urandom), 1'($urandom), w,
               ($urandom_range(0, 3) == 0), 16'($urandom),
               int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_timeout();
    test_pslverr();
    test_err_clr_collide();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
